// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg: opcodes, parser states and default geometry shared by the SSD1306 SPI sink.
package ssd1306_pkg;
  localparam logic [7:0] OP_SET_PAGE = 8'h22;
  localparam logic [7:0] OP_SET_COL = 8'h21;
  localparam int DEF_COLS = 128;
  localparam int DEF_PAGES = 8;
  typedef enum logic [1:0] {P_CMD, P_ARG1, P_ARG2} parse_state_t;
endpackage

// File: rtl/spi_rx_shift.sv
// spi_rx_shift: synchronises SPI mode-0 pins into clk and assembles MSB-first bytes.
module spi_rx_shift (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  input  logic       spi_dc,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);
  logic [1:0] sck_s, mosi_s, cs_s, dc_s;
  logic       sck_q;
  logic [2:0] bitcnt;
  logic       rise;
  assign rise = sck_s[1] & ~sck_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      sck_s <= '0;
      mosi_s <= '0;
      cs_s <= '1;
      dc_s <= '0;
      sck_q <= 1'b0;
      bitcnt <= '0;
      byte_data <= '0;
      byte_valid <= 1'b0;
      byte_dc <= 1'b0;
    end else begin
      sck_s <= {sck_s[0], spi_sck};
      mosi_s <= {mosi_s[0], spi_mosi};
      cs_s <= {cs_s[0], spi_cs_n};
      dc_s <= {dc_s[0], spi_dc};
      sck_q <= sck_s[1];
      byte_valid <= 1'b0;
      if (cs_s[1]) bitcnt <= '0;
      else if (rise) begin
        byte_data <= {byte_data[6:0], mosi_s[1]};
        bitcnt <= bitcnt + 3'd1;
        if (bitcnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_dc <= dc_s[1];
        end
      end
    end
endmodule

// File: rtl/ssd1306_spi_sink.sv
// ssd1306_spi_sink: decodes SSD1306 SPI command/data traffic into framebuffer writes.
// Define SSD1306_SINK_COLADDR_EN to decode the 0x21 column-address command.
module ssd1306_spi_sink
  import ssd1306_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int PAGES = DEF_PAGES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          spi_sck,
  input  logic                          spi_mosi,
  input  logic                          spi_cs_n,
  input  logic                          spi_dc,
  output logic                          fb_we,
  output logic [$clog2(COLS*PAGES)-1:0] fb_addr,
  output logic [7:0]                    fb_wdata,
  output logic                          cmd_valid,
  output logic [7:0]                    cmd_byte,
  output logic                          frame_done,
  output logic [2:0]                    cur_page,
  output logic [6:0]                    cur_col
);
  localparam int AW = $clog2(COLS * PAGES);
  localparam logic [2:0] PMASK = 3'(PAGES - 1);
  localparam logic [6:0] CMASK = 7'(COLS - 1);
`ifdef SSD1306_SINK_COLADDR_EN
  localparam int ARG_W = 7;
`else
  localparam int ARG_W = 3;
`endif
  logic             bv, bdc;
  logic [7:0]       bd;
  parse_state_t     state, state_nx;
  logic [ARG_W-1:0] arg_start, arg_m;
  logic [2:0]       page_start, page_end, page_nx;
  logic [6:0]       col_start, col_end, col_nx;
  logic             col_wrap, page_wrap, addr_op, pend_col;
  spi_rx_shift u_rx (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .spi_dc(spi_dc),
    .byte_valid(bv), .byte_data(bd), .byte_dc(bdc)
  );
`ifdef SSD1306_SINK_COLADDR_EN
  logic [7:0] pending;
  assign pend_col = pending == OP_SET_COL;
  assign addr_op = bd == OP_SET_PAGE || bd == OP_SET_COL;
  assign arg_m = pend_col ? bd[6:0] & CMASK : {4'b0, bd[2:0] & PMASK};
  always_ff @(posedge clk)
    if (!rst_n) begin
      pending <= '0;
      col_start <= '0;
      col_end <= CMASK;
    end else if (bv && !bdc) begin
      if (state == P_CMD) pending <= bd;
      if (state == P_ARG2 && pend_col) begin
        col_start <= arg_start;
        col_end <= arg_m;
      end
    end
`else
  assign pend_col = 1'b0;
  assign addr_op = bd == OP_SET_PAGE;
  assign arg_m = bd[2:0] & PMASK;
  assign col_start = '0;
  assign col_end = CMASK;
`endif
  // A data byte always aborts an in-flight argument sequence.
  always_comb begin
    state_nx = state;
    if (bv)
      state_nx = bdc ? P_CMD :
                 state == P_CMD ? (addr_op ? P_ARG1 : P_CMD) :
                 state == P_ARG1 ? P_ARG2 : P_CMD;
  end
  // Wrapping windows step modulo the display size until they hit the end.
  always_comb begin
    col_wrap = cur_col == col_end;
    page_wrap = cur_page == page_end;
    col_nx = col_wrap ? col_start : (cur_col + 7'd1) & CMASK;
    page_nx = !col_wrap ? cur_page : page_wrap ? page_start : (cur_page + 3'd1) & PMASK;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= P_CMD;
      fb_we <= 1'b0;
      fb_addr <= '0;
      fb_wdata <= '0;
      cmd_valid <= 1'b0;
      cmd_byte <= '0;
      frame_done <= 1'b0;
      cur_page <= '0;
      cur_col <= '0;
      page_start <= '0;
      page_end <= PMASK;
      arg_start <= '0;
    end else begin
      state <= state_nx;
      fb_we <= 1'b0;
      cmd_valid <= 1'b0;
      frame_done <= 1'b0;
      if (bv && bdc) begin
        fb_we <= 1'b1;
        fb_addr <= AW'(cur_page * COLS + cur_col);
        fb_wdata <= bd;
        cur_col <= col_nx;
        cur_page <= page_nx;
        frame_done <= col_wrap & page_wrap;
      end
      if (bv && !bdc) begin
        cmd_valid <= 1'b1;
        cmd_byte <= bd;
        if (state == P_ARG1) arg_start <= arg_m;
        if (state == P_ARG2 && pend_col) cur_col <= 7'(arg_start);
        if (state == P_ARG2 && !pend_col) begin
          page_start <= arg_start[2:0];
          page_end <= arg_m[2:0];
          cur_page <= arg_start[2:0];
        end
      end
    end
endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// tb_ssd1306_spi_sink: directed self-checking bench for ssd1306_spi_sink.
module tb_ssd1306_spi_sink;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sck = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1, spi_dc = 1'b0;
  logic       fb_we, cmd_valid, frame_done;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata, cmd_byte;
  logic [2:0] cur_page;
  logic [6:0] cur_col;
  int         checks = 0, errors = 0;
  int         wr_n = 0, cmd_n = 0, frame_n = 0;
  logic [9:0] wr_addr [0:299];
  logic [7:0] wr_data [0:299];
  logic       wr_frame [0:299];
  logic [7:0] cmd_last;
  always #5 clk = ~clk;
  ssd1306_spi_sink dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .spi_dc(spi_dc), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_wdata(fb_wdata), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .frame_done(frame_done), .cur_page(cur_page), .cur_col(cur_col)
  );
  always @(negedge clk) begin
    if (fb_we && wr_n < 300) begin
      wr_addr[wr_n] = fb_addr;
      wr_data[wr_n] = fb_wdata;
      wr_frame[wr_n] = frame_done;
    end
    if (fb_we) wr_n++;
    if (frame_done) frame_n++;
    if (cmd_valid) begin
      cmd_n++;
      cmd_last = cmd_byte;
    end
  end
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    spi_cs_n = 1'b1;
    spi_sck = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wr_n = 0;
    cmd_n = 0;
    frame_n = 0;
    @(negedge clk);
  endtask
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      repeat (4) @(negedge clk);
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic dc);
    @(negedge clk);
    spi_dc = dc;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(b, 8);
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we got %0b exp 0", fb_we); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got %0b exp 0", cmd_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0b exp 0", frame_done); end
    checks++; if (fb_addr !== 10'd0) begin errors++; $display("FAIL reset_fb_addr got %0d exp 0", fb_addr); end
    checks++; if (fb_wdata !== 8'h00) begin errors++; $display("FAIL reset_fb_wdata got %0h exp 0", fb_wdata); end
    checks++; if (cmd_byte !== 8'h00) begin errors++; $display("FAIL reset_cmd_byte got %0h exp 0", cmd_byte); end
    checks++; if (cur_page !== 3'd0) begin errors++; $display("FAIL reset_cur_page got %0d exp 0", cur_page); end
    checks++; if (cur_col !== 7'd0) begin errors++; $display("FAIL reset_cur_col got %0d exp 0", cur_col); end
  endtask
  task automatic test_data();
    do_reset();
    send_byte(8'hA5, 1'b1);
    checks++; if (wr_n !== 1) begin errors++; $display("FAIL data_count got %0d exp 1", wr_n); end
    checks++; if (wr_addr[0] !== 10'd0) begin errors++; $display("FAIL data_addr got %0d exp 0", wr_addr[0]); end
    checks++; if (wr_data[0] !== 8'hA5) begin errors++; $display("FAIL data_wdata got %0h exp a5", wr_data[0]); end
    checks++; if (cur_col !== 7'd1) begin errors++; $display("FAIL data_cur_col got %0d exp 1", cur_col); end
    checks++; if (cmd_n !== 0) begin errors++; $display("FAIL data_no_cmd got %0d exp 0", cmd_n); end
  endtask
  task automatic test_page_cmd();
    do_reset();
    send_byte(8'h22, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h05, 1'b0);
    checks++; if (cur_page !== 3'd3) begin errors++; $display("FAIL page_load got %0d exp 3", cur_page); end
    send_byte(8'h11, 1'b1);
    checks++; if (cmd_n !== 3) begin errors++; $display("FAIL page_cmd_count got %0d exp 3", cmd_n); end
    checks++; if (cmd_last !== 8'h05) begin errors++; $display("FAIL page_cmd_byte got %0h exp 05", cmd_last); end
    checks++; if (wr_n !== 1 || wr_addr[0] !== 10'd384) begin errors++; $display("FAIL page_addr got %0d (n=%0d) exp 384", wr_addr[0], wr_n); end
    checks++; if (wr_data[0] !== 8'h11) begin errors++; $display("FAIL page_wdata got %0h exp 11", wr_data[0]); end
    checks++; if (cur_page !== 3'd3 || cur_col !== 7'd1) begin errors++; $display("FAIL page_ptr got %0d/%0d exp 3/1", cur_page, cur_col); end
  endtask
  task automatic test_frame_wrap();
    do_reset();
    send_byte(8'h22, 1'b0);
    send_byte(8'h06, 1'b0);
    send_byte(8'h07, 1'b0);
    for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b1);
    checks++; if (wr_n !== 256) begin errors++; $display("FAIL wrap_count got %0d exp 256", wr_n); end
    checks++; if (wr_addr[0] !== 10'd768) begin errors++; $display("FAIL wrap_first got %0d exp 768", wr_addr[0]); end
    checks++; if (wr_addr[128] !== 10'd896) begin errors++; $display("FAIL wrap_page7 got %0d exp 896", wr_addr[128]); end
    checks++; if (wr_addr[255] !== 10'd1023 || wr_data[255] !== 8'hFF) begin errors++; $display("FAIL wrap_last got %0d/%0h exp 1023/ff", wr_addr[255], wr_data[255]); end
    checks++; if (wr_frame[255] !== 1'b1) begin errors++; $display("FAIL wrap_frame_on_last got %0b exp 1", wr_frame[255]); end
    checks++; if (frame_n !== 1) begin errors++; $display("FAIL wrap_frame_count got %0d exp 1", frame_n); end
    checks++; if (cur_page !== 3'd6 || cur_col !== 7'd0) begin errors++; $display("FAIL wrap_ptr got %0d/%0d exp 6/0", cur_page, cur_col); end
  endtask
  task automatic test_col_cmd();
    logic [9:0] e0, e1, e2;
    logic [2:0] ep;
    logic [6:0] ec;
`ifdef SSD1306_SINK_COLADDR_EN
    e0 = 10'd16; e1 = 10'd17; e2 = 10'd144; ep = 3'd1; ec = 7'd17;
`else
    e0 = 10'd0; e1 = 10'd1; e2 = 10'd2; ep = 3'd0; ec = 7'd3;
`endif
    do_reset();
    send_byte(8'h21, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h11, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h50 + 8'(i), 1'b1);
    checks++; if (cmd_n !== 3) begin errors++; $display("FAIL col_cmd_count got %0d exp 3", cmd_n); end
    checks++; if (wr_n !== 3) begin errors++; $display("FAIL col_wr_count got %0d exp 3", wr_n); end
    checks++; if (wr_addr[0] !== e0 || wr_addr[1] !== e1 || wr_addr[2] !== e2) begin errors++; $display("FAIL col_addrs got %0d,%0d,%0d exp %0d,%0d,%0d", wr_addr[0], wr_addr[1], wr_addr[2], e0, e1, e2); end
    checks++; if (cur_page !== ep || cur_col !== ec) begin errors++; $display("FAIL col_ptr got %0d/%0d exp %0d/%0d", cur_page, cur_col, ep, ec); end
  endtask
  task automatic test_fragment();
    do_reset();
    @(negedge clk);
    spi_dc = 1'b1;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(8'hFF, 5);
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    send_byte(8'h3C, 1'b1);
    checks++; if (wr_n !== 1) begin errors++; $display("FAIL frag_count got %0d exp 1", wr_n); end
    checks++; if (wr_data[0] !== 8'h3C || wr_addr[0] !== 10'd0) begin errors++; $display("FAIL frag_write got %0h@%0d exp 3c@0", wr_data[0], wr_addr[0]); end
    checks++; if (cmd_n !== 0) begin errors++; $display("FAIL frag_no_cmd got %0d exp 0", cmd_n); end
  endtask
  task automatic test_abort();
    do_reset();
    send_byte(8'h22, 1'b0);
    send_byte(8'h77, 1'b1);
    checks++; if (wr_n !== 1 || wr_data[0] !== 8'h77 || wr_addr[0] !== 10'd0) begin errors++; $display("FAIL abort_write got %0h@%0d (n=%0d) exp 77@0", wr_data[0], wr_addr[0], wr_n); end
    send_byte(8'h05, 1'b0);
    send_byte(8'h06, 1'b0);
    send_byte(8'h12, 1'b1);
    checks++; if (wr_n !== 2 || wr_addr[1] !== 10'd1) begin errors++; $display("FAIL abort_parser got %0d (n=%0d) exp 1", wr_addr[1], wr_n); end
    checks++; if (cur_page !== 3'd0 || cur_col !== 7'd2) begin errors++; $display("FAIL abort_ptr got %0d/%0d exp 0/2", cur_page, cur_col); end
  endtask
  task automatic test_latency();
    do_reset();
    @(negedge clk);
    spi_dc = 1'b1;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(8'h9B, 7);
    spi_mosi = 1'b1;
    repeat (4) @(negedge clk);
    spi_sck = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL latency_early got %0b exp 0", fb_we); end
    @(negedge clk);
    checks++; if (fb_we !== 1'b1 || fb_wdata !== 8'h9B) begin errors++; $display("FAIL latency_strobe got %0b/%0h exp 1/9b", fb_we, fb_wdata); end
    @(negedge clk);
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL latency_single got %0b exp 0", fb_we); end
    repeat (3) @(negedge clk);
    spi_sck = 1'b0;
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
  endtask
  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    spi_dc = 1'b1;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(8'hC3, 8);
    send_bits(8'h5A, 8);
    repeat (6) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (wr_n !== 2 || wr_data[0] !== 8'hC3 || wr_data[1] !== 8'h5A) begin errors++; $display("FAIL b2b_data got %0h,%0h (n=%0d) exp c3,5a", wr_data[0], wr_data[1], wr_n); end
    checks++; if (wr_addr[1] !== 10'd1) begin errors++; $display("FAIL b2b_addr got %0d exp 1", wr_addr[1]); end
  endtask
  initial begin
    test_reset();
    test_data();
    test_page_cmd();
    test_frame_wrap();
    test_col_cmd();
    test_fragment();
    test_abort();
    test_latency();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ssd1306_spi_sink.md
# ssd1306_spi_sink

SPI-mode-0 receiver that sits on the far end of the OLED display link and decodes SSD1306 command and data traffic into framebuffer writes. It synchronises the bus pins (SCK, MOSI, CS, DC) into `clk`, assembles bytes MSB-first, and tracks the page and column address commands. Each data byte becomes a single-cycle write strobe to an external framebuffer RAM. The block serves as the on-chip loopback/monitor target for the waveform plotter and as a bench-side display model.

## Interface
Parameters:
- `COLS`, 128, display columns; power of two, ≤128.
- `PAGES`, 8, display pages (8 rows each); power of two, ≤8.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `spi_sck`  in  1  serial clock, asynchronous, CPOL=0.
- `spi_mosi`  in  1  serial data, asynchronous.
- `spi_cs_n`  in  1  chip select, active-low, asynchronous.
- `spi_dc`  in  1  data(1)/command(0), asynchronous.
- `fb_we`  out  1  one-cycle framebuffer write strobe.
- `fb_addr`  out  $clog2(COLS*PAGES)  write address, `page*COLS + col`.
- `fb_wdata`  out  8  pixel byte; bit0 is the top row of the page.
- `cmd_valid`  out  1  one-cycle pulse for every command byte.
- `cmd_byte`  out  8  raw command byte, valid with `cmd_valid`.
- `frame_done`  out  1  one-cycle pulse when the write pointer wraps from the window end to the window start.
- `cur_page`  out  3  current page pointer.
- `cur_col`  out  7  current column pointer.

## Operation
- All four bus inputs pass through 2-flop synchronisers. A SCK rising edge is detected on the synchronised SCK (previous 0, current 1).
- On each rising edge while synchronised CS is low: `shift <= {shift[6:0], mosi}` and `bitcnt++`.
- On the 8th edge the byte completes. DC is sampled from the synchronised DC on that same edge, and `bitcnt` returns to 0.
- CS high clears `bitcnt` immediately. A partial byte is discarded with no output.
- Parser FSM, states `P_CMD`, `P_ARG1`, `P_ARG2`, with a `pending` opcode register:
  - Command byte in `P_CMD`: pulse `cmd_valid`.
    - Opcode 0x22 → `P_ARG1`, pending=0x22.
    - Opcode 0x21 (macro-gated) → `P_ARG1`, pending=0x21.
    - Any other opcode stays in `P_CMD`. All other opcodes are single-byte; their parameters are reported on `cmd_valid` and not otherwise interpreted.
  - `P_ARG1`, command byte: store `start` (0x22: bits[2:0] mod PAGES; 0x21: bits[6:0] mod COLS), pulse `cmd_valid`, → `P_ARG2`.
  - `P_ARG2`, command byte: store `end` with the same masking, pulse `cmd_valid`, and load the window. 0x22 sets `page_start/page_end` and `cur_page=page_start`. 0x21 sets `col_start/col_end` and `cur_col=col_start`. → `P_CMD`.
  - Data byte in any state: the parser returns to `P_CMD`, any partial argument sequence is dropped with the window unchanged, and the write is still performed.
- Data write (horizontal addressing):
  - Pulse `fb_we` with `fb_addr=cur_page*COLS+cur_col`, `fb_wdata=byte`.
  - Column advance: if `cur_col==col_end`, then `cur_col=col_start`; otherwise `cur_col` increments.
  - Page advance on column wrap: if `cur_page==page_end`, then `cur_page=page_start` and `frame_done` pulses; otherwise `cur_page` increments.
  - start > end windows: the pointer increments modulo COLS/PAGES until it equals end.
- Reset values:
  - Outputs `fb_we`, `cmd_valid`, `frame_done`, `fb_addr`, `fb_wdata`, `cmd_byte` = 0.
  - Pointers: `cur_page=0`, `cur_col=0`.
  - Windows: page 0..PAGES-1, col 0..COLS-1.
  - Parser state `P_CMD`, `bitcnt=0`.
- Reset mid-byte or mid-argument drops all partial state. Reset has priority over a simultaneous byte completion.

## Timing
- Latency: `fb_we`/`cmd_valid` assert 4 clk cycles after the raw SCK rising edge of bit 7. This is 2 synchroniser stages + 1 edge detect + 1 registered output.
- `fb_we` and `frame_done` assert in the same cycle. Pointers update in that same cycle, so they show post-increment values afterwards.
- SCK high and low phases must each be ≥3 clk cycles (transmitter prescaler ≥2). Faster SCK is unsupported.
- CS and DC must be stable ≥3 clk cycles before the first SCK edge and after the last SCK edge.
- Back-to-back bytes produce strobes at least 6 clk cycles apart. No buffering is needed.

## Configuration
- `SSD1306_SINK_COLADDR_EN` defined: 0x21 column-address command decoded as above.
- Not defined: 0x21 is treated as a plain single-byte command. The column window is fixed at 0..COLS-1, and `col_start/col_end` registers are removed.

## Structure
- `ssd1306_pkg` holds:
  - Opcode constants `OP_SET_PAGE=8'h22` and `OP_SET_COL=8'h21`.
  - Parser state enum `parse_state_t`.
  - Default `COLS`/`PAGES` values.
- Sub-module `spi_rx_shift` contains the synchronisers, edge detect, `bitcnt` and the shift register. Its outputs are `byte_valid`, `byte`, and `byte_dc`. The parser and address logic live in the top level.

## Test plan
- Reset, then one data byte 0xA5 with DC=1 → `fb_we` once, `fb_addr=0`, `fb_wdata=0xA5`, `cur_col=1`.
- Commands 0x22,0x03,0x05 (DC=0), then data 0x11 → three `cmd_valid` pulses; write at `fb_addr=3*128=384`, `cur_page=3`.
- With window page 6..7, send 256 data bytes → the last write is at `fb_addr=7*128+127=1023`, `frame_done` pulses on it, and the pointer returns to page 6 col 0.
- Commands 0x21,0x10,0x11 (macro on), then 3 data bytes → addresses 16, 17, 128+16. With the macro off → addresses 0, 1, 2.
- 5 bits clocked, then CS high, then full byte 0x3C (DC=1) → a single write of 0x3C, no write from the fragment.
- Command 0x22 then data 0x77 → parser back in `P_CMD`, page window unchanged, write 0x77 at the current pointer.
